// File: rtl/pd_sequencer.sv
// pd_sequencer: multi-domain power-gating sequencer.
//
// Each of NUM_DOM domains runs its own sleep/wake sequence:
//   ON -> ISO_ENTER -> RET_ENTER -> PSW_OFF -> OFF -> PSW_ON -> RET_EXIT -> ISO_EXIT -> ON
// with ISO_CYC / RET_CYC / PSW_CYC dwell cycles per timed phase.
// A single switch token limits supply switching to one domain at a time.
//
// Ports:
//   clk                    rising-edge clock
//   reset                  asynchronous, active-high reset (all domains to ON)
//   sleep_req[i]           level request, 1 = domain i should be powered off
//   sleep_ack[i]           1 only while domain i is in OFF
//   isolation_enable[i]    1 = domain i outputs clamped
//   state_retention_enable 1 = retention save/hold
//   power_switch_enable[i] 1 = domain i supply switched off
//   dom_state              per-domain state code, domain i at [3i+2:3i]
//   busy                   some domain is in a transitional (non ON/OFF) state
//
// Handshake: sleep_req is a level, not a pulse. sleep_ack rises only once the
// supply is off and drops on the same edge the wake sequence starts.
module pd_sequencer #(
  parameter int NUM_DOM = 4,
  parameter int CNT_W   = 8,
  parameter int ISO_CYC = 8,
  parameter int RET_CYC = 10,
  parameter int PSW_CYC = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_DOM-1:0]   sleep_req,
  output logic [NUM_DOM-1:0]   sleep_ack,
  output logic [NUM_DOM-1:0]   isolation_enable,
  output logic [NUM_DOM-1:0]   state_retention_enable,
  output logic [NUM_DOM-1:0]   power_switch_enable,
  output logic [3*NUM_DOM-1:0] dom_state,
  output logic                 busy
);

  typedef enum logic [2:0] {
    ST_ON        = 3'd0,
    ST_ISO_ENTER = 3'd1,
    ST_RET_ENTER = 3'd2,
    ST_PSW_OFF   = 3'd3,
    ST_OFF       = 3'd4,
    ST_PSW_ON    = 3'd5,
    ST_RET_EXIT  = 3'd6,
    ST_ISO_EXIT  = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] ISO_LAST = CNT_W'(ISO_CYC - 1);
  localparam logic [CNT_W-1:0] RET_LAST = CNT_W'(RET_CYC - 1);
  localparam logic [CNT_W-1:0] PSW_LAST = CNT_W'(PSW_CYC - 1);

  // Terminal dwell count of a timed state.
  function automatic logic [CNT_W-1:0] last_count(input state_t s);
    case (s)
      ST_ISO_ENTER, ST_ISO_EXIT: last_count = ISO_LAST;
      ST_RET_ENTER, ST_RET_EXIT: last_count = RET_LAST;
      ST_PSW_OFF,   ST_PSW_ON:   last_count = PSW_LAST;
      default:                   last_count = '0;
    endcase
  endfunction

  state_t             state_q [NUM_DOM];
  state_t             state_d [NUM_DOM];
  logic [CNT_W-1:0]   cnt_q   [NUM_DOM];
  logic [CNT_W-1:0]   cnt_d   [NUM_DOM];
  logic [NUM_DOM-1:0] done;
  logic [NUM_DOM-1:0] tok_req;
  logic [NUM_DOM-1:0] grant;
  logic               holder_stays;
  logic               taken;
  logic               busy_d;

  // Token arbitration. A holder that is finishing its switch phase on this
  // edge releases the token on the same edge, so a waiting domain can take
  // it immediately and the switch phases run back to back without overlap.
  always_comb begin
    holder_stays = 1'b0;
    done         = '0;
    tok_req      = '0;
    for (int i = 0; i < NUM_DOM; i++) begin
      done[i] = (state_q[i] != ST_ON) && (state_q[i] != ST_OFF) &&
                (cnt_q[i] == last_count(state_q[i]));
      tok_req[i] = ((state_q[i] == ST_RET_ENTER) && done[i] && sleep_req[i]) ||
                   ((state_q[i] == ST_OFF) && !sleep_req[i]);
      if (((state_q[i] == ST_PSW_OFF) || (state_q[i] == ST_PSW_ON)) && !done[i])
        holder_stays = 1'b1;
    end
    grant = '0;
    taken = holder_stays;
    for (int i = 0; i < NUM_DOM; i++) begin
      if (tok_req[i] && !taken) begin
        grant[i] = 1'b1;
        taken    = 1'b1;
      end
    end
  end

  // Per-domain next state and dwell counter.
  always_comb begin
    busy_d = 1'b0;
    for (int i = 0; i < NUM_DOM; i++) begin
      state_d[i] = state_q[i];
      if ((state_q[i] == ST_ON) || (state_q[i] == ST_OFF))
        cnt_d[i] = '0;
      else if (!done[i])
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      else
        cnt_d[i] = cnt_q[i];  // saturated while waiting for the token

      case (state_q[i])
        ST_ON:        if (sleep_req[i]) state_d[i] = ST_ISO_ENTER;
        ST_ISO_ENTER: if (!sleep_req[i]) state_d[i] = ST_ISO_EXIT;
                      else if (done[i]) state_d[i] = ST_RET_ENTER;
        ST_RET_ENTER: if (!sleep_req[i]) state_d[i] = ST_RET_EXIT;
                      else if (done[i] && grant[i]) state_d[i] = ST_PSW_OFF;
        ST_PSW_OFF:   if (done[i]) state_d[i] = ST_OFF;
        ST_OFF:       if (grant[i]) state_d[i] = ST_PSW_ON;
        ST_PSW_ON:    if (done[i]) state_d[i] = ST_RET_EXIT;
        ST_RET_EXIT:  if (done[i]) state_d[i] = ST_ISO_EXIT;
        ST_ISO_EXIT:  if (done[i]) state_d[i] = ST_ON;
        default:      state_d[i] = ST_ON;
      endcase

      if (state_d[i] != state_q[i]) cnt_d[i] = '0;
      if ((state_d[i] != ST_ON) && (state_d[i] != ST_OFF)) busy_d = 1'b1;
    end
  end

  // State and outputs share one register stage: outputs are decoded from the
  // next state so they change on the same edge as the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_DOM; i++) begin
        state_q[i] <= ST_ON;
        cnt_q[i]   <= '0;
      end
      sleep_ack              <= '0;
      isolation_enable       <= '0;
      state_retention_enable <= '0;
      power_switch_enable    <= '0;
      busy                   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_DOM; i++) begin
        state_q[i]                <= state_d[i];
        cnt_q[i]                  <= cnt_d[i];
        isolation_enable[i]       <= (state_d[i] != ST_ON);
        state_retention_enable[i] <= (state_d[i] == ST_RET_ENTER) || (state_d[i] == ST_PSW_OFF) ||
                                     (state_d[i] == ST_OFF)       || (state_d[i] == ST_PSW_ON);
        power_switch_enable[i]    <= (state_d[i] == ST_PSW_OFF) || (state_d[i] == ST_OFF);
        sleep_ack[i]              <= (state_d[i] == ST_OFF);
      end
      busy <= busy_d;
    end
  end

  for (genvar g = 0; g < NUM_DOM; g++) begin : g_state_out
    assign dom_state[3*g +: 3] = state_q[g];
  end

endmodule
